// File: rtl/cpu_tick_sequencer.sv
// CPU tick sequencer: generates a divided TICK clock in run, single-step or
// burst mode, with graceful stop that never truncates a high phase.
module cpu_tick_sequencer #(
  parameter int unsigned N            = 8,
  parameter int unsigned DEFAULT_HALF = 8,
  parameter int unsigned BURST_W      = 8
) (
  input  logic               MAIN_CLOCK,
  input  logic               RESET_N,
  input  logic               START_PROCESSING_FLAG,
  input  logic               PROCESS_FINISHED,
  input  logic [1:0]         MODE,
  input  logic               STEP_REQ,
  input  logic [N-1:0]       HALF_PERIOD,
  input  logic [BURST_W-1:0] BURST_LEN,
  input  logic               LOAD_CFG,
  output logic               TICK,
  output logic               TICK_RISE,
  output logic               BUSY,
  output logic               DONE,
  output logic [15:0]        TICK_COUNT
);

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_STEP_WAIT, S_STEP, S_BURST, S_HALT
  } state_t;

  state_t             state, state_next;
  logic [1:0]         mode_q;
  logic [N-1:0]       half_q;
  logic [BURST_W-1:0] len_q;
  logic [N-1:0]       cnt, cnt_next;
  logic [BURST_W-1:0] bursts, bursts_next;
  logic               pend, pend_next;
  logic               tick_next;
  logic               step_q;
  logic               leave_idle;
  logic               stop;
  logic               step_edge;
  logic               wrap;
  logic               active_next;

  assign stop        = PROCESS_FINISHED | ~START_PROCESSING_FLAG;
  assign step_edge   = STEP_REQ & ~step_q;
  assign wrap        = (cnt == half_q - N'(1));
  assign active_next = (state_next == S_RUN) || (state_next == S_STEP_WAIT) ||
                       (state_next == S_STEP) || (state_next == S_BURST);

  // Next-state and next-datapath decode
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    bursts_next = bursts;
    pend_next   = pend;
    tick_next   = TICK;
    leave_idle  = 1'b0;
    case (state)
      S_IDLE: begin
        tick_next = 1'b0;
        cnt_next  = '0;
        pend_next = 1'b0;
        if (START_PROCESSING_FLAG && !PROCESS_FINISHED) begin
          leave_idle  = 1'b1;
          bursts_next = '0;
          case (mode_q)
            2'b01:   state_next = S_STEP_WAIT;
            2'b10:   state_next = S_BURST;
            default: state_next = S_RUN;
          endcase
        end
      end
      S_STEP_WAIT: begin
        tick_next = 1'b0;
        cnt_next  = '0;
        if (stop) begin
          state_next = S_HALT;
        end else if (step_edge) begin
          state_next = S_STEP;
        end
      end
      S_RUN, S_STEP, S_BURST: begin
        // With TICK low a stop (or an empty burst) halts immediately; a pending
        // rise is simply suppressed, so no partial high phase is ever emitted.
        if (!TICK && (stop || (state == S_BURST && len_q == '0))) begin
          state_next = S_HALT;
          cnt_next   = '0;
        end else begin
          cnt_next = wrap ? '0 : cnt + N'(1);
          if (wrap) begin
            tick_next = ~TICK;
          end
          if (TICK) begin
            pend_next = pend | stop;
            if (wrap) begin
              if (pend || stop) begin
                state_next = S_HALT;
              end else if (state == S_STEP) begin
                state_next = S_STEP_WAIT;
              end else if (state == S_BURST) begin
                if (bursts == len_q - BURST_W'(1)) begin
                  state_next = S_HALT;
                end else begin
                  bursts_next = bursts + BURST_W'(1);
                end
              end
            end
          end
        end
      end
      S_HALT: begin
        tick_next = 1'b0;
        cnt_next  = '0;
        pend_next = 1'b0;
        if (!START_PROCESSING_FLAG) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
        tick_next  = 1'b0;
        cnt_next   = '0;
      end
    endcase
  end

  // State register
  always_ff @(posedge MAIN_CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Counters and registered outputs
  always_ff @(posedge MAIN_CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt        <= '0;
      bursts     <= '0;
      pend       <= 1'b0;
      step_q     <= 1'b0;
      TICK       <= 1'b0;
      TICK_RISE  <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      TICK_COUNT <= '0;
    end else begin
      cnt       <= cnt_next;
      bursts    <= bursts_next;
      pend      <= pend_next;
      step_q    <= STEP_REQ;
      TICK      <= tick_next;
      TICK_RISE <= tick_next & ~TICK;
      BUSY      <= active_next;
      DONE      <= (state_next == S_HALT) && (state != S_HALT);
      if (leave_idle) begin
        TICK_COUNT <= '0;
      end else if (tick_next && !TICK && (TICK_COUNT != 16'hFFFF)) begin
        TICK_COUNT <= TICK_COUNT + 16'd1;
      end
    end
  end

  // Configuration latch, writable only while idle
  always_ff @(posedge MAIN_CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      mode_q <= 2'b00;
      half_q <= N'(DEFAULT_HALF);
      len_q  <= '0;
    end else if (state == S_IDLE && LOAD_CFG) begin
      mode_q <= MODE;
      half_q <= (HALF_PERIOD == '0) ? N'(DEFAULT_HALF) : HALF_PERIOD;
      len_q  <= BURST_LEN;
    end
  end

endmodule

// File: tb/tb_cpu_tick_sequencer.sv
// Self-checking bench for cpu_tick_sequencer: directed and randomized
// scenarios compared against an arithmetic waveform model.
module tb_cpu_tick_sequencer;

  localparam int unsigned N  = 8;
  localparam int unsigned BW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          pf;
  logic [1:0]    mode;
  logic          step_req;
  logic [N-1:0]  half;
  logic [BW-1:0] blen;
  logic          load;
  logic          tick;
  logic          tick_rise;
  logic          busy;
  logic          done;
  logic [15:0]   tick_count;

  int n_cmp  = 0;
  int n_fail = 0;

  cpu_tick_sequencer #(.N(N), .DEFAULT_HALF(8), .BURST_W(BW)) dut (
    .MAIN_CLOCK            (clk),
    .RESET_N               (rst_n),
    .START_PROCESSING_FLAG (start),
    .PROCESS_FINISHED      (pf),
    .MODE                  (mode),
    .STEP_REQ              (step_req),
    .HALF_PERIOD           (half),
    .BURST_LEN             (blen),
    .LOAD_CFG              (load),
    .TICK                  (tick),
    .TICK_RISE             (tick_rise),
    .BUSY                  (busy),
    .DONE                  (done),
    .TICK_COUNT            (tick_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    n_cmp++;
    assert (obs === 32'(exp)) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int k, input int et, input int er,
                            input int eb, input int ed, input int ec);
    chk($sformatf("%s k=%0d tick", tag, k), 32'(tick), et);
    chk($sformatf("%s k=%0d tick_rise", tag, k), 32'(tick_rise), er);
    chk($sformatf("%s k=%0d busy", tag, k), 32'(busy), eb);
    chk($sformatf("%s k=%0d done", tag, k), 32'(done), ed);
    chk($sformatf("%s k=%0d tick_count", tag, k), 32'(tick_count), ec);
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic load_cfg(input logic [1:0] m, input int hp, input int len);
    mode = m;
    half = N'(hp);
    blen = BW'(len);
    load = 1'b1;
    step_clk();
    load = 1'b0;
  endtask

  // Ideal free-running waveform, k cycles after leaving IDLE with half-period h
  function automatic int nat_tick(input int k, input int h);
    return (k / h) % 2;
  endfunction

  function automatic int nat_rise(input int k, input int h);
    return (k >= h && (k % (2 * h)) == h) ? 1 : 0;
  endfunction

  function automatic int nat_cnt(input int k, input int h);
    return (k < h) ? 0 : ((k - h) / (2 * h) + 1);
  endfunction

  // Run/burst scenario: s is the cycle after which a stop is driven (-1: none)
  task automatic scenario(input string tag, input int h, input bit burst, input int len,
                          input int s, input bit use_pf);
    int nat_end;
    int stop_halt;
    int halt;
    nat_end = burst ? ((len == 0) ? 1 : 2 * h * len) : 32'h4000_0000;
    if (s < 0) stop_halt = 32'h4000_0000;
    else if (nat_tick(s, h) == 0) stop_halt = s + 1;
    else stop_halt = ((s / (2 * h)) + 1) * 2 * h;
    halt = (nat_end < stop_halt) ? nat_end : stop_halt;
    start = 1'b1;
    pf    = 1'b0;
    step_clk();
    for (int k = 0; k <= halt + 2; k++) begin
      if (k < halt) check_outs(tag, k, nat_tick(k, h), nat_rise(k, h), 1, 0, nat_cnt(k, h));
      else check_outs(tag, k, 0, 0, 0, (k == halt) ? 1 : 0, nat_cnt(halt - 1, h));
      load = 1'b0;
      if (k == s) begin
        if (use_pf) pf = 1'b1;
        else start = 1'b0;
      end else if ((k + 1 < halt) && (s < 0 || k < s)) begin
        // configuration writes while active must have no effect
        load = 1'b1;
        half = N'($urandom_range(1, 3));
        mode = 2'($urandom);
        blen = BW'($urandom);
      end
      if (k == halt) begin
        start = 1'b0;
        pf    = 1'b0;
      end
      step_clk();
    end
    start = 1'b0;
    pf    = 1'b0;
    load  = 1'b0;
  endtask

  // Single-step scenario with three requests, the second inside an active step
  task automatic step_test(input string tag, input int h);
    int r1, r2, r3, kend, et, er, ec;
    int reqs[3];
    int acc[$];
    bit ok;
    r1 = $urandom_range(2, 5);
    r2 = r1 + $urandom_range(2, 2 * h - 1);
    r3 = r1 + 2 * h + $urandom_range(2, 4);
    reqs[0] = r1; reqs[1] = r2; reqs[2] = r3;
    acc.delete();
    foreach (reqs[i]) begin
      ok = 1'b1;
      foreach (acc[j]) if (reqs[i] >= acc[j] + 1 && reqs[i] <= acc[j] + 2 * h) ok = 1'b0;
      if (ok) acc.push_back(reqs[i]);
    end
    kend = r3 + 2 * h + 2;
    step_req = 1'b0;
    start    = 1'b1;
    pf       = 1'b0;
    step_clk();
    for (int k = 0; k <= kend + 3; k++) begin
      et = 0; er = 0; ec = 0;
      foreach (acc[j]) begin
        if (k >= acc[j] + h && k < acc[j] + 2 * h) et = 1;
        if (k == acc[j] + h) er = 1;
        if (k >= acc[j] + h) ec++;
      end
      if (k <= kend) check_outs(tag, k, et, er, 1, 0, ec);
      else check_outs(tag, k, 0, 0, 0, (k == kend + 1) ? 1 : 0, ec);
      step_req = (k + 1 == r1) || (k + 1 == r2) || (k + 1 == r3);
      if (k == kend) start = 1'b0;
      step_clk();
    end
    step_req = 1'b0;
    start    = 1'b0;
  endtask

  initial begin
    int m, hp, h, len, s;
    bit use_pf;
    rst_n = 1'b0; start = 1'b0; pf = 1'b0; mode = 2'b00; step_req = 1'b0;
    half = '0; blen = '0; load = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outs("reset", 0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b1;
    step_clk();
    check_outs("idle", 0, 0, 0, 0, 0, 0);

    scenario("run_default", 8, 1'b0, 0, 90, 1'b0);
    scenario("graceful", 8, 1'b0, 0, 9, 1'b1);
    load_cfg(2'b10, 3, 4);
    scenario("burst", 3, 1'b1, 4, -1, 1'b0);
    load_cfg(2'b10, 2, 3);
    scenario("burst_stop_last_fall", 2, 1'b1, 3, 11, 1'b1);
    load_cfg(2'b10, 4, 0);
    scenario("burst_zero", 4, 1'b1, 0, -1, 1'b0);
    load_cfg(2'b01, 2, 0);
    step_test("step", 2);

    for (int it = 0; it < 8; it++) begin
      m = $urandom_range(0, 3);
      if (m == 1) begin
        h = $urandom_range(2, 6);
        load_cfg(2'b01, h, 0);
        step_test($sformatf("rnd%0d_step", it), h);
      end else begin
        hp     = $urandom_range(0, 9);
        h      = (hp == 0) ? 8 : hp;
        len    = $urandom_range(0, 5);
        use_pf = 1'($urandom);
        s      = (m == 2 && $urandom_range(0, 1) == 1) ? -1 : int'($urandom_range(0, 6 * h));
        load_cfg(2'(m), hp, len);
        scenario($sformatf("rnd%0d_m%0d_h%0d", it, m, h), h, (m == 2), len, s, use_pf);
      end
    end

    // Asynchronous reset during a high phase, then config must be back to defaults
    load_cfg(2'b10, 3, 5);
    start = 1'b1;
    step_clk();
    for (int k = 0; k <= 4; k++) begin
      check_outs("pre_reset", k, nat_tick(k, 3), nat_rise(k, 3), 1, 0, nat_cnt(k, 3));
      if (k < 4) step_clk();
    end
    #2 rst_n = 1'b0;
    #1;
    check_outs("async_reset", 0, 0, 0, 0, 0, 0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    scenario("post_reset_defaults", 8, 1'b0, 0, 20, 1'b0);
    load_cfg(2'b00, 5, 0);
    load_cfg(2'b00, 0, 0);
    scenario("half_zero", 8, 1'b0, 0, 30, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
